// File: rtl/screen_ram_arbiter.sv
// Purpose : shares the single-port 8-bit screen RAM between the VGA renderer (absolute priority)
//           and the 6502 bus, using a 1-entry posted write buffer with read forwarding.
// Latency : VGA read data 1 cycle after vga_read_en. CPU write, forwarded read and out-of-window
//           access ack 1 cycle after sampling. A RAM read acks 2 cycles after it is issued.
// Backpressure: cpu_ack is withheld while the buffer is busy with another address or a read waits
//           for a VGA-free cycle. The VGA path is never stalled.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request, held stable until cpu_ack
//   cpu_rdata, cpu_ack             read data and registered 1-cycle completion pulse
//   vga_read_en/addr, vga_read_data  renderer fetch port (data = ram_rdata)
//   ram_en/we/addr/wdata, ram_rdata  single-port synchronous RAM interface
module screen_ram_arbiter #(
    parameter logic [15:0] BASE       = 16'h0200,
    parameter int          WINDOW     = 1024,
    parameter int          ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [15:0]           cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  vga_read_en,
    input  logic [ADDR_WIDTH-1:0] vga_read_addr,
    output logic [7:0]            vga_read_data,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2
    } state_t;

    // Window bounds held at 17 bits so BASE+WINDOW cannot wrap at the top of the map.
    localparam logic [16:0] WIN_LO = {1'b0, BASE};
    localparam logic [16:0] WIN_HI = {1'b0, BASE} + 17'(WINDOW);

    state_t                  state_q;
    logic                    cpu_ack_q;
    logic [7:0]              cpu_rdata_q;
    logic                    wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0]   wb_addr_q,  wb_addr_d;
    logic [7:0]              wb_data_q,  wb_data_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;

    logic                    req_smp;
    logic                    in_win;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic                    wb_hit;
    logic                    rd_issue;
    logic                    drain;
    logic                    wr_accept;

    assign cpu_ack       = cpu_ack_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign vga_read_data = ram_rdata;

    // A request is not sampled in the ack cycle, so a held cpu_req is never accepted twice.
    assign req_smp   = (state_q == IDLE) && !cpu_ack_q && cpu_req;
    assign in_win    = ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);
    assign req_addr  = cpu_addr[ADDR_WIDTH-1:0];
    assign wb_hit    = wb_valid_q && (wb_addr_q == req_addr);
    assign rd_issue  = (state_q == RD_ISSUE) && !vga_read_en;
    assign drain     = !vga_read_en && wb_valid_q && !rd_issue;
    // A write is taken if the buffer is empty, holds the same address (coalesce),
    // or is emptying on this very edge.
    assign wr_accept = req_smp && in_win && cpu_we && (!wb_valid_q || wb_hit || drain);

    // RAM port mux: VGA, then CPU read issue, then buffer drain.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = wb_addr_q;
        ram_wdata = wb_data_q;
        if (vga_read_en) begin
            ram_en   = 1'b1;
            ram_addr = vga_read_addr;
        end else if (rd_issue) begin
            ram_en   = 1'b1;
            ram_addr = rd_addr_q;
        end else if (drain) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
        end
    end

    // Write buffer next state. Capture wins over drain-clear so that a drain and a new
    // write on the same edge leave the new write pending.
    always_comb begin
        wb_valid_d = wb_valid_q && !drain;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        if (wr_accept) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = req_addr;
            wb_data_d  = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= 8'h00;
            rd_addr_q   <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            cpu_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_smp) begin
                        if (!in_win) begin
                            // Outside the screen page: writes vanish, reads return zero.
                            cpu_ack_q   <= 1'b1;
                            cpu_rdata_q <= 8'h00;
                        end else if (cpu_we) begin
                            if (wr_accept) begin
                                cpu_ack_q   <= 1'b1;
                                cpu_rdata_q <= 8'h00;
                            end
                        end else if (wb_hit) begin
                            // Buffered data is newer than RAM for this address.
                            cpu_ack_q   <= 1'b1;
                            cpu_rdata_q <= wb_data_q;
                        end else begin
                            rd_addr_q <= req_addr;
                            state_q   <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    if (!vga_read_en) begin
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cpu_rdata_q <= ram_rdata;
                    cpu_ack_q   <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screen_ram_arbiter.sv
module tb_screen_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        vga_read_en;
    logic [10:0] vga_read_addr;
    logic [7:0]  vga_read_data;
    logic        ram_en;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    screen_ram_arbiter #(
        .BASE       (16'h0200),
        .WINDOW     (1024),
        .ADDR_WIDTH (11)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .cpu_ack       (cpu_ack),
        .vga_read_en   (vga_read_en),
        .vga_read_addr (vga_read_addr),
        .vga_read_data (vga_read_data),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       chk;
        logic [7:0] d;
    } exp_t;

    logic [7:0] mem    [0:2047];
    logic [7:0] shadow [0:2047];
    exp_t       cpu_q[$];
    logic [7:0] vga_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int last_we_cyc = -1;
    int cpu_rd_cnt = 0;
    int last_crd_cyc = -1;
    logic [10:0] last_we_addr = '0;
    logic [7:0]  last_we_data = '0;

    function automatic logic [7:0] init_val(input int i);
        return 8'(i) ^ 8'h5C;
    endfunction

    function automatic logic in_win(input logic [15:0] a);
        return (a >= 16'h0200) && (a < 16'h0600);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port RAM, read-first, 1-cycle read latency.
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = init_val(i);
        ram_rdata = 8'h00;
        forever begin
            @(posedge clk);
            if (ram_en) begin
                if (ram_we) mem[ram_addr] = ram_wdata;
                else        ram_rdata <= mem[ram_addr];
            end
        end
    end

    // Scoreboard consumer and RAM traffic log, sampled on the falling edge.
    task automatic monitor();
        exp_t       e;
        logic [7:0] v;
        forever begin
            @(negedge clk);
            if (vga_q.size() > 0) begin
                v = vga_q.pop_front();
                checks++;
                if (vga_read_data !== v) begin
                    errors++;
                    $display("FAIL vga_data: got %02h expected %02h at cyc %0d", vga_read_data, v, cyc);
                end
            end
            if (vga_read_en) vga_q.push_back(mem[vga_read_addr]);
            if (cpu_ack) begin
                if (cpu_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack with empty queue at cyc %0d", cyc);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.chk) begin
                        checks++;
                        if (cpu_rdata !== e.d) begin
                            errors++;
                            $display("FAIL cpu_rdata: got %02h expected %02h at cyc %0d", cpu_rdata, e.d, cyc);
                        end
                    end
                end
            end
            if (ram_en && ram_we) begin
                we_cnt++;
                last_we_cyc  = cyc;
                last_we_addr = ram_addr;
                last_we_data = ram_wdata;
            end
            if (ram_en && !ram_we && !vga_read_en) begin
                cpu_rd_cnt++;
                last_crd_cyc = cyc;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the ack cycle. lat = cycles from request to ack.
    task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                          output int lat, output int t_req);
        exp_t e;
        int   n;
        logic hit;
        e.chk = !we;
        e.d   = in_win(addr) ? shadow[addr[10:0]] : 8'h00;
        if (we && in_win(addr)) shadow[addr[10:0]] = wd;
        cpu_q.push_back(e);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        t_req = cyc;
        n = 0; hit = 1'b0;
        while (!hit && n < 300) begin
            @(negedge clk);
            if (cpu_ack) hit = 1'b1;
            else n++;
        end
        lat = n;
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: addr %04h no ack after %0d cycles", addr, n);
            void'(cpu_q.pop_back());
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        int lat, t, n;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vga_read_en = 1'b0; vga_read_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0)   begin errors++; $display("FAIL reset_ack: got %b expected 0", cpu_ack); end
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %02h expected 00", cpu_rdata); end
        checks++; if (ram_en !== 1'b0)    begin errors++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
        @(posedge clk); #1;
        reset = 1'b0;
        // Park a write in the buffer behind VGA traffic, then reset over it.
        vga_read_en = 1'b1; vga_read_addr = 11'h010;
        cpu_op(1'b1, 16'h0250, 8'h77, lat, t);
        checks++; if (lat != 1) begin errors++; $display("FAIL rst_wr_lat: got %0d expected 1", lat); end
        n = we_cnt;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; vga_read_en = 1'b0;
        shadow[11'h250] = init_val(11'h250);  // buffered write is lost
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0)   begin errors++; $display("FAIL post_rst_ack: got %b expected 0", cpu_ack); end
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL post_rst_rdata: got %02h expected 00", cpu_rdata); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (we_cnt != n) begin errors++; $display("FAIL post_rst_drain: got %0d writes expected %0d", we_cnt, n); end
        cpu_op(1'b0, 16'h0250, 8'h00, lat, t);
        checks++; if (lat != 3) begin errors++; $display("FAIL rst_rd_lat: got %0d expected 3", lat); end
    endtask

    task automatic test_write_read();
        int lat, t;
        vga_read_en = 1'b0;
        cpu_op(1'b1, 16'h0234, 8'h5A, lat, t);
        checks++; if (lat != 1) begin errors++; $display("FAIL wr_lat: got %0d expected 1", lat); end
        checks++;
        if (last_we_cyc != t + 1 || last_we_addr !== 11'h234 || last_we_data !== 8'h5A) begin
            errors++;
            $display("FAIL wr_drain: got cyc %0d addr %03h data %02h expected cyc %0d addr 234 data 5a",
                     last_we_cyc, last_we_addr, last_we_data, t + 1);
        end
        cpu_op(1'b0, 16'h0234, 8'h00, lat, t);
        checks++; if (lat != 3) begin errors++; $display("FAIL rd_lat: got %0d expected 3", lat); end
        checks++; if (last_crd_cyc != t + 1) begin errors++; $display("FAIL rd_issue_cyc: got %0d expected %0d", last_crd_cyc, t + 1); end
    endtask

    task automatic test_forward();
        int lat, t, n;
        vga_read_en = 1'b1;
        n = we_cnt;
        cpu_op(1'b1, 16'h0300, 8'h11, lat, t);
        checks++; if (lat != 1) begin errors++; $display("FAIL fwd_wr_lat: got %0d expected 1", lat); end
        cpu_op(1'b0, 16'h0300, 8'h00, lat, t);
        checks++; if (lat != 1) begin errors++; $display("FAIL fwd_rd_lat: got %0d expected 1", lat); end
        for (int i = 0; i < 14; i++) begin
            vga_read_addr = 11'($urandom_range(0, 2047));
            @(posedge clk); #1;
        end
        checks++; if (we_cnt != n) begin errors++; $display("FAIL fwd_no_drain: got %0d writes expected %0d", we_cnt, n); end
        vga_read_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (we_cnt != n + 1 || last_we_addr !== 11'h300 || last_we_data !== 8'h11) begin
            errors++;
            $display("FAIL fwd_drain: got %0d writes addr %03h data %02h expected %0d writes addr 300 data 11",
                     we_cnt, last_we_addr, last_we_data, n + 1);
        end
    endtask

    task automatic test_stall();
        int   lat, t, n, d, acks;
        exp_t e;
        vga_read_en = 1'b1;
        cpu_op(1'b1, 16'h0300, 8'h21, lat, t);
        checks++; if (lat != 1) begin errors++; $display("FAIL stall_wr1_lat: got %0d expected 1", lat); end
        n = we_cnt;
        e.chk = 1'b0; e.d = 8'h00;
        cpu_q.push_back(e);
        shadow[11'h301] = 8'h22;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0301; cpu_wdata = 8'h22;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_ack) acks++;
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL stall_hold: got %0d acks expected 0", acks); end
        @(posedge clk); #1;
        vga_read_en = 1'b0;
        d = cyc;
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL stall_early_ack: got %b expected 0", cpu_ack); end
        @(posedge clk); #1;
        checks++;
        if (last_we_cyc != d || last_we_addr !== 11'h300 || last_we_data !== 8'h21) begin
            errors++;
            $display("FAIL stall_drain: got cyc %0d addr %03h data %02h expected cyc %0d addr 300 data 21",
                     last_we_cyc, last_we_addr, last_we_data, d);
        end
        @(negedge clk);
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL stall_ack: got %b expected 1", cpu_ack); end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (we_cnt != n + 2 || last_we_addr !== 11'h301 || last_we_data !== 8'h22) begin
            errors++;
            $display("FAIL stall_second_drain: got %0d writes addr %03h data %02h expected %0d writes addr 301 data 22",
                     we_cnt, last_we_addr, last_we_data, n + 2);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, lat, t, n;
        vga_read_en = 1'b1;
        n = we_cnt;
        cpu_op(1'b1, 16'h0400, 8'hAA, lat1, t);
        cpu_op(1'b1, 16'h0400, 8'hBB, lat2, t);
        checks++; if (lat1 != 1 || lat2 != 1) begin errors++; $display("FAIL b2b_lat: got %0d,%0d expected 1,1", lat1, lat2); end
        checks++; if (we_cnt != n) begin errors++; $display("FAIL b2b_no_drain: got %0d writes expected %0d", we_cnt, n); end
        vga_read_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (we_cnt != n + 1 || last_we_addr !== 11'h400 || last_we_data !== 8'hBB) begin
            errors++;
            $display("FAIL b2b_drain: got %0d writes addr %03h data %02h expected %0d writes addr 400 data bb",
                     we_cnt, last_we_addr, last_we_data, n + 1);
        end
        cpu_op(1'b0, 16'h0400, 8'h00, lat, t);
    endtask

    task automatic test_out_of_window();
        logic [15:0] oow [3];
        int lat, t, nr, nw;
        oow[0] = 16'h0600; oow[1] = 16'h01FF; oow[2] = 16'hFFFF;
        vga_read_en = 1'b0;
        nr = cpu_rd_cnt; nw = we_cnt;
        for (int i = 0; i < 3; i++) begin
            cpu_op(1'b0, oow[i], 8'h00, lat, t);
            checks++; if (lat != 1) begin errors++; $display("FAIL oow_rd_lat: addr %04h got %0d expected 1", oow[i], lat); end
        end
        cpu_op(1'b1, 16'h0600, 8'h99, lat, t);
        checks++; if (lat != 1) begin errors++; $display("FAIL oow_wr_lat: got %0d expected 1", lat); end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (cpu_rd_cnt != nr || we_cnt != nw) begin
            errors++;
            $display("FAIL oow_ram: got %0d reads %0d writes expected %0d reads %0d writes", cpu_rd_cnt, we_cnt, nr, nw);
        end
        cpu_op(1'b0, 16'h05FF, 8'h00, lat, t);
        checks++; if (lat != 3) begin errors++; $display("FAIL edge_hi_lat: got %0d expected 3", lat); end
        cpu_op(1'b0, 16'h0200, 8'h00, lat, t);
        checks++; if (lat != 3) begin errors++; $display("FAIL edge_lo_lat: got %0d expected 3", lat); end
    endtask

    task automatic test_random();
        fork
            begin
                repeat (600) begin
                    vga_read_en   = 1'($urandom_range(0, 1));
                    vga_read_addr = 11'($urandom_range(0, 2047));
                    @(posedge clk); #1;
                end
                vga_read_en = 1'b0;
            end
            begin
                int lat, t;
                logic [15:0] a;
                for (int k = 0; k < 60; k++) begin
                    if ($urandom_range(0, 9) == 0) a = 16'h0600 + 16'($urandom_range(0, 15));
                    else                          a = 16'h0200 + 16'($urandom_range(0, 7));
                    cpu_op(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)), lat, t);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        checks++; if (cpu_q.size() != 0) begin errors++; $display("FAIL rand_drain_q: got %0d pending expected 0", cpu_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) shadow[i] = init_val(i);
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vga_read_en = 1'b0; vga_read_addr = '0;
        fork monitor(); join_none
        @(posedge clk); #1;
        test_reset();
        test_write_read();
        test_forward();
        test_stall();
        test_back_to_back();
        test_out_of_window();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
